// File: rtl/ofifo_lockstep_pkg.sv
// Shared widths and error-flag bit positions for the lock-step output FIFO.
// The error flags are built only when OFIFO_ERR_FLAGS_EN is defined.
package ofifo_lockstep_pkg;

    localparam int OFIFO_ERR_OVF = 0;
    localparam int OFIFO_ERR_UDF = 1;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/ofifo_lane.sv
// Single-column first-word-fall-through FIFO: the head entry is a combinational
// read at the read pointer, and count, full and empty come from the registered count.
module ofifo_lane
    import ofifo_lockstep_pkg::*;
#(
    parameter int bw    = 4,
    parameter int depth = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [bw-1:0]               din,
    input  logic                        push,
    input  logic                        pop,
    output logic [cnt_width(depth)-1:0] count,
    output logic                        full,
    output logic                        empty,
    output logic [bw-1:0]               head
);

    localparam int PW = ptr_width(depth);
    localparam int CW = cnt_width(depth);

    logic [bw-1:0] mem [depth];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (count == CW'(depth));
    assign empty = (count == '0);
    assign head  = mem[rptr];

    // A full lane still takes a write when the row is popped in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + PW'(1);
            if (pop_ok)  rptr <= rptr + PW'(1);
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // NOTE: storage has no reset; the count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[wptr] <= din;
    end

endmodule

// File: rtl/ofifo_lockstep.sv
// Column-parallel output FIFO: lanes fill independently, rows pop atomically.
// Defining OFIFO_ERR_FLAGS_EN adds the sticky o_err overflow/underflow port.
module ofifo_lockstep
    import ofifo_lockstep_pkg::*;
#(
    parameter int col       = 8,
    parameter int bw        = 4,
    parameter int depth     = 64,
    parameter int af_margin = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [bw*col-1:0]           in,
    input  logic [col-1:0]              wr,
    input  logic                        rd,
    output logic [bw*col-1:0]           out,
    output logic                        o_valid,
    output logic                        o_full,
    output logic                        o_ready,
    output logic                        o_almost_full,
    output logic [cnt_width(depth)-1:0] o_rows
`ifdef OFIFO_ERR_FLAGS_EN
    ,
    output logic [1:0]                  o_err
`endif
);

    localparam int CW    = cnt_width(depth);
    localparam int AF_TH = depth - af_margin;

    logic [col-1:0] full_v;
    logic [col-1:0] empty_v;
    logic [CW-1:0]  cnt [col];
    logic           pop;

    for (genvar i = 0; i < col; i++) begin : g_lane
        ofifo_lane #(
            .bw    (bw),
            .depth (depth)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .din   (in[bw*i +: bw]),
            .push  (wr[i]),
            .pop   (pop),
            .count (cnt[i]),
            .full  (full_v[i]),
            .empty (empty_v[i]),
            .head  (out[bw*i +: bw])
        );
    end

    assign o_valid = ~|empty_v;
    assign pop     = rd && o_valid;
    assign o_full  = |full_v;
    assign o_ready = !o_full;

    // NOTE: defaults first so every path through the loop assigns both outputs (no latch).
    always_comb begin
        o_rows        = cnt[0];
        o_almost_full = 1'b0;
        for (int i = 0; i < col; i++) begin
            if (cnt[i] < o_rows) o_rows = cnt[i];
            if (int'(cnt[i]) >= AF_TH) o_almost_full = 1'b1;
        end
    end

`ifdef OFIFO_ERR_FLAGS_EN
    logic ovf_evt;

    assign ovf_evt = (|(wr & full_v)) && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            o_err <= '0;
        end else begin
            if (ovf_evt)          o_err[OFIFO_ERR_OVF] <= 1'b1;
            if (rd && !o_valid)   o_err[OFIFO_ERR_UDF] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ofifo_lockstep.sv
// Self-checking bench for ofifo_lockstep: a default instance and a small-depth instance,
// both checked every cycle against a queue-per-lane model (o_err when OFIFO_ERR_FLAGS_EN).
module tb_ofifo_lockstep;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Instance A: col=8, bw=4, depth=64, af_margin=4
    logic [31:0] in_a = '0;
    logic [7:0]  wr_a = '0;
    logic        rd_a = 1'b0;
    logic [31:0] out_a;
    logic        valid_a, full_a, ready_a, af_a;
    logic [6:0]  rows_a;

    // Instance B: col=4, bw=16, depth=4, af_margin=1
    logic [63:0] in_b = '0;
    logic [3:0]  wr_b = '0;
    logic        rd_b = 1'b0;
    logic [63:0] out_b;
    logic        valid_b, full_b, ready_b, af_b;
    logic [2:0]  rows_b;

`ifdef OFIFO_ERR_FLAGS_EN
    logic [1:0] err_a, err_b;
`endif

    ofifo_lockstep u_dut_a (
        .clk (clk), .reset (reset), .in (in_a), .wr (wr_a), .rd (rd_a),
        .out (out_a), .o_valid (valid_a), .o_full (full_a), .o_ready (ready_a),
        .o_almost_full (af_a), .o_rows (rows_a)
`ifdef OFIFO_ERR_FLAGS_EN
        , .o_err (err_a)
`endif
    );

    ofifo_lockstep #(.col(4), .bw(16), .depth(4), .af_margin(1)) u_dut_b (
        .clk (clk), .reset (reset), .in (in_b), .wr (wr_b), .rd (rd_b),
        .out (out_b), .o_valid (valid_b), .o_full (full_b), .o_ready (ready_b),
        .o_almost_full (af_b), .o_rows (rows_b)
`ifdef OFIFO_ERR_FLAGS_EN
        , .o_err (err_b)
`endif
    );

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: one queue per lane, configured for whichever instance is selected.
    int          sel = 0;
    int          m_col = 8, m_bw = 4, m_depth = 64, m_af = 4;
    logic [15:0] mq [8][$];
    logic        m_ovf = 1'b0, m_udf = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_valid();
        for (int i = 0; i < m_col; i++) if (mq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 8; i++) mq[i].delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
    endtask

    task automatic model_step(input logic [7:0] w, input logic [63:0] d, input logic r);
        logic        v, p;
        logic [15:0] mask, val;
        logic [7:0]  acc;
        v    = model_valid();
        p    = r && v;
        mask = 16'((32'd1 << m_bw) - 1);
        acc  = '0;
        if (r && !v) m_udf = 1'b1;
        for (int i = 0; i < m_col; i++) begin
            if (w[i]) begin
                if (mq[i].size() < m_depth || p) acc[i] = 1'b1;
                else m_ovf = 1'b1;
            end
        end
        for (int i = 0; i < m_col; i++) begin
            if (p) void'(mq[i].pop_front());
            if (acc[i]) begin
                val = 16'(d >> (i * m_bw)) & mask;
                mq[i].push_back(val);
            end
        end
    endtask

    task automatic compare(input string tag);
        logic        e_valid, e_full, e_af;
        int          e_rows;
        logic [63:0] e_out;
        e_valid = model_valid();
        e_rows  = m_depth;
        e_full  = 1'b0;
        e_af    = 1'b0;
        e_out   = '0;
        for (int i = 0; i < m_col; i++) begin
            if (mq[i].size() < e_rows) e_rows = mq[i].size();
            if (mq[i].size() == m_depth) e_full = 1'b1;
            if (mq[i].size() >= m_depth - m_af) e_af = 1'b1;
            if (e_valid) e_out |= 64'(mq[i][0]) << (i * m_bw);
        end
        check({tag, ".valid"}, sel != 0 ? 64'(valid_b) : 64'(valid_a), 64'(e_valid));
        check({tag, ".rows"},  sel != 0 ? 64'(rows_b)  : 64'(rows_a),  64'(e_rows));
        check({tag, ".full"},  sel != 0 ? 64'(full_b)  : 64'(full_a),  64'(e_full));
        check({tag, ".ready"}, sel != 0 ? 64'(ready_b) : 64'(ready_a), 64'(!e_full));
        check({tag, ".af"},    sel != 0 ? 64'(af_b)    : 64'(af_a),    64'(e_af));
        if (e_valid)
            check({tag, ".out"}, sel != 0 ? out_b : 64'(out_a), e_out);
`ifdef OFIFO_ERR_FLAGS_EN
        check({tag, ".err"}, sel != 0 ? 64'(err_b) : 64'(err_a), 64'({m_udf, m_ovf}));
`endif
    endtask

    task automatic cycle(input string tag, input logic [7:0] w, input logic [63:0] d, input logic r);
        if (sel != 0) begin
            wr_b = w[3:0]; in_b = d; rd_b = r;
        end else begin
            wr_a = w; in_a = d[31:0]; rd_a = r;
        end
        @(posedge clk);
        model_step(w, d, r);
        #1;
        compare(tag);
    endtask

    // Reset is asserted with busy inputs to show that wr and rd are ignored.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        wr_a = '1; rd_a = 1'b1; in_a = 32'(~0);
        wr_b = '1; rd_b = 1'b1; in_b = '1;
        @(posedge clk);
        model_clear();
        #1;
        reset = 1'b0;
        wr_a = '0; rd_a = 1'b0;
        wr_b = '0; rd_b = 1'b0;
        compare(tag);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Instance A: reset state, then one full row written and popped.
        do_reset("reset_a");
        cycle("row_write", 8'hFF, 64'h7654_3210, 1'b0);
        check("row_out_const", 64'(out_a), 64'h7654_3210);
        check("row_rows_const", 64'(rows_a), 64'd1);
        cycle("row_pop", 8'h00, 64'h0, 1'b1);

        // Skewed fill: valid only once the slowest lane has been written.
        for (int k = 0; k < 8; k++)
            cycle("skew", 8'(1 << k), {$urandom, $urandom}, 1'b0);
        cycle("skew_pop", 8'h00, 64'h0, 1'b1);

        // Underflow: rd with nothing stored.
        cycle("udf", 8'h00, 64'h0, 1'b1);

        // Reset discards five stored rows and clears sticky flags.
        for (int k = 0; k < 5; k++)
            cycle("pre_reset", 8'hFF, {$urandom, $urandom}, 1'b0);
        do_reset("reset_mid");

        // Lane 0 alone: almost-full after 60 writes, full after 64, 65th dropped.
        for (int k = 0; k < 65; k++)
            cycle("lane0_fill", 8'h01, {$urandom, $urandom}, 1'b0);
        for (int k = 0; k < 64; k++)
            cycle("others_fill", 8'hFE, {$urandom, $urandom}, 1'b0);

        // Full FIFO with simultaneous push and pop across the wrap.
        for (int k = 0; k < 10; k++)
            cycle("full_pp", 8'hFF, {$urandom, $urandom}, 1'b1);
        for (int k = 0; k < 64; k++)
            cycle("drain", 8'h00, 64'h0, 1'b1);

        for (int k = 0; k < 300; k++)
            cycle("rand_a", 8'($urandom | $urandom), {$urandom, $urandom}, 1'($urandom_range(0, 1)));

        // Instance B: small depth, af_margin=1.
        sel = 1; m_col = 4; m_bw = 16; m_depth = 4; m_af = 1;
        do_reset("reset_b");
        for (int k = 0; k < 3; k++)
            cycle("b_fill3", 8'h0F, {$urandom, $urandom}, 1'b0);
        check("b_af3", 64'(af_b), 64'd1);
        check("b_full3", 64'(full_b), 64'd0);
        cycle("b_fill4", 8'h0F, {$urandom, $urandom}, 1'b0);
        check("b_full4", 64'(full_b), 64'd1);
        for (int k = 0; k < 400; k++)
            cycle("rand_b", 8'($urandom | $urandom) & 8'h0F, {$urandom, $urandom}, 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
